mem_access: RTL and testbench

//  bexkat1 memory stage, directly downstream of execute. Performs T_LOAD/T_STORE
//  bus cycles on the data bus using execute's result as the address, stalls

---
 rtl/mem_access_pkg.sv | 25 ++
 rtl/mem_access_lane.sv | 38 +++
 rtl/mem_access.sv | 155 +++++++++++++++
 tb/tb_mem_access.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - bexkat1 instruction types and memory-stage enums for mem_access
package mem_access_pkg;

    typedef enum logic [3:0] {
        T_INH, T_PUSH, T_POP, T_CMP, T_MOV, T_FP, T_ALU, T_INT,
        T_LDI, T_LOAD, T_STORE, T_BRANCH, T_JUMP, T_INTU, T_FPU
    } insn_type_t;

    typedef enum logic [1:0] {MS_WORD, MS_HALF, MS_BYTE} memsize_t;

    typedef enum logic {S_IDLE, S_BUS} memstate_t;

    localparam int IR_TYPE_LSB = 28;
    localparam int IR_OP_LSB   = 24;

    // ir_op[1:0] == 3 is treated as a word access
    function automatic memsize_t op_to_size(input logic [1:0] op);
        case (op)
            2'd1:    return MS_HALF;
            2'd2:    return MS_BYTE;
            default: return MS_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_lane.sv
// rtl/mem_access_lane.sv - big-endian byte-lane select, store replication and load extract
module mem_lane
    import mem_access_pkg::*;
(
    input  memsize_t    size,
    input  logic [1:0]  lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  sel,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    always_comb begin
        sel      = 4'b1111;
        st_lanes = st_data;
        ld_data  = ld_raw;
        case (size)
            MS_HALF: begin
                sel      = lo[1] ? 4'b0011 : 4'b1100;
                st_lanes = {2{st_data[15:0]}};
                ld_data  = {16'h0000, lo[1] ? ld_raw[15:0] : ld_raw[31:16]};
            end
            MS_BYTE: begin
                sel      = 4'b1000 >> lo;
                st_lanes = {4{st_data[7:0]}};
                case (lo)
                    2'd0:    ld_data = {24'h0, ld_raw[31:24]};
                    2'd1:    ld_data = {24'h0, ld_raw[23:16]};
                    2'd2:    ld_data = {24'h0, ld_raw[15:8]};
                    default: ld_data = {24'h0, ld_raw[7:0]};
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - bexkat1 memory stage; optional bus timeout via MEM_ACCESS_TIMEOUT_EN
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] ir_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] result_i,
    input  logic [31:0] reg_data1_i,
    input  logic [1:0]  reg_write_i,
    input  logic        halt_i,
    output logic        stall_o,
    output logic [63:0] ir_o,
    output logic [31:0] pc_o,
    output logic [31:0] result_o,
    output logic [1:0]  reg_write_o,
    output logic        halt_o,
    output logic        fault_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i
);

    memstate_t   state_q;
    memsize_t    size_q;
    logic [1:0]  lo_q;
    insn_type_t  ir_type;
    logic        is_mem;
    logic        timeout;
    logic        abort;
    logic        done;
    memsize_t    lane_size;
    logic [1:0]  lane_lo;
    logic [3:0]  lane_sel;
    logic [31:0] lane_st;
    logic [31:0] lane_ld;

    // Elaboration-time guard: the counter must be able to reach TIMEOUT
    if (2 ** CNT_W <= TIMEOUT) begin : g_cnt_w_too_small
    end

    assign ir_type = insn_type_t'(ir_i[IR_TYPE_LSB +: 4]);
    assign is_mem  = (ir_type == T_LOAD) || (ir_type == T_STORE);

    // Idle: lanes come from the incoming op; on the bus: from the latched op
    assign lane_size = (state_q == S_IDLE) ? op_to_size(ir_i[IR_OP_LSB +: 2]) : size_q;
    assign lane_lo   = (state_q == S_IDLE) ? result_i[1:0] : lo_q;

    mem_lane u_lane (
        .size     (lane_size),
        .lo       (lane_lo),
        .st_data  (reg_data1_i),
        .ld_raw   (bus_dat_i),
        .sel      (lane_sel),
        .st_lanes (lane_st),
        .ld_data  (lane_ld)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    assign timeout = (state_q == S_BUS) && (cnt_q == CNT_W'(TIMEOUT - 1))
                     && !bus_ack_i && !bus_err_i;
`else
    assign timeout = 1'b0;
`endif

    assign abort   = bus_err_i || timeout;
    assign done    = bus_ack_i || abort;
    assign stall_o = rst_i && ((state_q == S_IDLE) ? is_mem : !done);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            size_q      <= MS_WORD;
            lo_q        <= '0;
            ir_o        <= '0;
            pc_o        <= '0;
            result_o    <= '0;
            reg_write_o <= '0;
            halt_o      <= 1'b0;
            fault_o     <= 1'b0;
            bus_cyc_o   <= 1'b0;
            bus_stb_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_adr_o   <= '0;
            bus_sel_o   <= '0;
            bus_dat_o   <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            fault_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (is_mem) begin
                        ir_o        <= '0;
                        reg_write_o <= '0;
                        halt_o      <= 1'b0;
                        bus_cyc_o   <= 1'b1;
                        bus_stb_o   <= 1'b1;
                        bus_we_o    <= (ir_type == T_STORE);
                        bus_adr_o   <= {result_i[31:2], 2'b00};
                        bus_sel_o   <= lane_sel;
                        bus_dat_o   <= lane_st;
                        size_q      <= lane_size;
                        lo_q        <= result_i[1:0];
                        state_q     <= S_BUS;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end else begin
                        ir_o        <= ir_i;
                        pc_o        <= pc_i;
                        result_o    <= result_i;
                        reg_write_o <= reg_write_i;
                        halt_o      <= halt_i;
                    end
                end
                S_BUS: begin
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_q <= cnt_q + CNT_W'(1);
`endif
                    if (done) begin
                        ir_o      <= ir_i;
                        pc_o      <= pc_i;
                        halt_o    <= halt_i;
                        bus_cyc_o <= 1'b0;
                        bus_stb_o <= 1'b0;
                        state_q   <= S_IDLE;
                        if (abort) begin
                            reg_write_o <= '0;
                            result_o    <= result_i;
                            fault_o     <= 1'b1;
                        end else begin
                            reg_write_o <= reg_write_i;
                            result_o    <= bus_we_o ? result_i : lane_ld;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed table plus randomized model checks for mem_access
module tb_mem_access;
    import mem_access_pkg::*;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1000000;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [63:0] ir_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] result_i = '0;
    logic [31:0] reg_data1_i = '0;
    logic [1:0]  reg_write_i = '0;
    logic        halt_i = 1'b0;
    logic        stall_o;
    logic [63:0] ir_o;
    logic [31:0] pc_o;
    logic [31:0] result_o;
    logic [1:0]  reg_write_o;
    logic        halt_o;
    logic        fault_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_adr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        bus_err_i = 1'b0;

    mem_access dut (
        .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .pc_i(pc_i), .result_i(result_i),
        .reg_data1_i(reg_data1_i), .reg_write_i(reg_write_i), .halt_i(halt_i),
        .stall_o(stall_o), .ir_o(ir_o), .pc_o(pc_o), .result_o(result_o),
        .reg_write_o(reg_write_o), .halt_o(halt_o), .fault_o(fault_o),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
        .bus_adr_o(bus_adr_o), .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
    );

    always #5 clk_i = ~clk_i;

    // resp: 0 = ack, 1 = err, 2 = ack and err together
    typedef struct {
        insn_type_t  typ;
        logic [3:0]  op;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] bdat;
        int          resp_k;
        int          resp;
        logic        stray;
        logic [1:0]  rw;
        logic        halt;
        logic [3:0]  exp_sel;
        logic [31:0] exp_dat;
        logic [31:0] exp_res;
        logic [1:0]  exp_rw;
        logic        exp_fault;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [3:0] op);
        if (op[1:0] == 2'd1) return 2;
        if (op[1:0] == 2'd2) return 1;
        return 4;
    endfunction

    function automatic int offs(input int n, input logic [31:0] adr);
        if (n == 4) return 0;
        if (n == 2) return adr[1] ? 2 : 0;
        return int'(adr[1:0]);
    endfunction

    function automatic logic [3:0] model_sel(input logic [3:0] op, input logic [31:0] adr);
        int n = nbytes(op);
        int o = offs(n, adr);
        logic [3:0] s = '0;
        for (int b = 0; b < 4; b++) s[3-b] = (b >= o) && (b < o + n);
        return s;
    endfunction

    function automatic logic [31:0] model_ld(input logic [3:0] op, input logic [31:0] adr,
                                             input logic [31:0] d);
        int n = nbytes(op);
        int o = offs(n, adr);
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        return 32'((64'(d) >> (8 * (4 - o - n))) & mask);
    endfunction

    function automatic logic [31:0] model_st(input logic [3:0] op, input logic [31:0] w);
        int n = nbytes(op);
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        logic [63:0] r = '0;
        for (int i = 0; i < 4 / n; i++) r = r | ((64'(w) & mask) << (8 * n * i));
        return r[31:0];
    endfunction

    // Called at a negedge; returns at the negedge on which the op's result is visible
    task automatic run_op(input vec_t v);
        logic [63:0] ir;
        logic [31:0] pc;
        logic        mem;
        int          end_k;
        int          stalls;
        ir    = {32'($urandom()), 4'(v.typ), v.op, 24'($urandom())};
        pc    = $urandom();
        mem   = (v.typ == T_LOAD) || (v.typ == T_STORE);
        end_k = (v.resp_k > TMO) ? TMO : v.resp_k;
        ir_i = ir; pc_i = pc; result_i = v.adr; reg_data1_i = v.wdat;
        reg_write_i = v.rw; halt_i = v.halt;
        bus_ack_i = v.stray; bus_err_i = v.stray; bus_dat_i = $urandom();
        #1 chk("stall_idle", 64'(stall_o), 64'(mem));
        @(negedge clk_i);
        bus_ack_i = 1'b0; bus_err_i = 1'b0;
        chk("fault_clear", 64'(fault_o), 64'd0);
        if (!mem) begin
            chk("alu_ir", ir_o, ir);
            chk("alu_pc", 64'(pc_o), 64'(pc));
            chk("alu_result", 64'(result_o), 64'(v.exp_res));
            chk("alu_reg_write", 64'(reg_write_o), 64'(v.exp_rw));
            chk("alu_halt", 64'(halt_o), 64'(v.halt));
            chk("alu_cyc", 64'(bus_cyc_o), 64'd0);
            return;
        end
        chk("bus_cyc", 64'(bus_cyc_o), 64'd1);
        chk("bus_stb", 64'(bus_stb_o), 64'd1);
        chk("bus_we", 64'(bus_we_o), 64'(v.typ == T_STORE));
        chk("bus_adr", 64'(bus_adr_o), 64'({v.adr[31:2], 2'b00}));
        chk("bus_sel", 64'(bus_sel_o), 64'(v.exp_sel));
        if (v.typ == T_STORE) chk("bus_dat", 64'(bus_dat_o), 64'(v.exp_dat));
        chk("bubble_ir", ir_o, 64'd0);
        chk("bubble_reg_write", 64'(reg_write_o), 64'd0);
        stalls = 1;
        for (int k = 1; k <= end_k; k++) begin
            if (k > 1) @(negedge clk_i);
            if (k == v.resp_k) begin
                bus_ack_i = (v.resp != 1);
                bus_err_i = (v.resp != 0);
                bus_dat_i = v.bdat;
            end
            #1;
            if (k < end_k) begin
                chk("stall_bus", 64'(stall_o), 64'd1);
                stalls++;
            end else begin
                chk("stall_release", 64'(stall_o), 64'd0);
            end
        end
        chk("stall_cycles", 64'(stalls), 64'(end_k));
        @(negedge clk_i);
        bus_ack_i = 1'b0; bus_err_i = 1'b0;
        chk("retire_cyc", 64'(bus_cyc_o), 64'd0);
        chk("retire_stb", 64'(bus_stb_o), 64'd0);
        chk("retire_ir", ir_o, ir);
        chk("retire_pc", 64'(pc_o), 64'(pc));
        chk("retire_halt", 64'(halt_o), 64'(v.halt));
        chk("retire_reg_write", 64'(reg_write_o), 64'(v.exp_rw));
        chk("retire_fault", 64'(fault_o), 64'(v.exp_fault));
        if (!v.exp_fault) chk("retire_result", 64'(result_o), 64'(v.exp_res));
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{T_ALU, 4'h0, 32'h0000_1234, 0, 0, 0, 0, 1'b0, 2'b01, 1'b0,
                   4'h0, 0, 32'h0000_1234, 2'b01, 1'b0};
        tbl[1] = '{T_LOAD, 4'h2, 32'h0000_0103, 0, 32'hAABB_CCDD, 3, 0, 1'b0, 2'b01, 1'b0,
                   4'b0001, 0, 32'h0000_00DD, 2'b01, 1'b0};
        tbl[2] = '{T_STORE, 4'h1, 32'h0000_0202, 32'h0000_BEEF, 0, 1, 0, 1'b0, 2'b10, 1'b0,
                   4'b0011, 32'hBEEF_BEEF, 32'h0000_0202, 2'b10, 1'b0};
        tbl[3] = '{T_LOAD, 4'h0, 32'h0000_0400, 0, 32'h1122_3344, 2, 2, 1'b0, 2'b11, 1'b0,
                   4'b1111, 0, 0, 2'b00, 1'b1};
        tbl[4] = '{T_LOAD, 4'h3, 32'h0000_1000, 0, 32'h1234_5678, 1, 0, 1'b1, 2'b01, 1'b1,
                   4'b1111, 0, 32'h1234_5678, 2'b01, 1'b0};
        tbl[5] = '{T_LOAD, 4'h5, 32'h0000_0101, 0, 32'hAABB_CCDD, 2, 0, 1'b0, 2'b11, 1'b0,
                   4'b1100, 0, 32'h0000_AABB, 2'b11, 1'b0};
        tbl[6] = '{T_STORE, 4'h2, 32'h0000_0002, 32'h1234_565A, 0, 1, 0, 1'b0, 2'b01, 1'b0,
                   4'b0010, 32'h5A5A_5A5A, 32'h0000_0002, 2'b01, 1'b0};
        tbl[7] = '{T_STORE, 4'h0, 32'h0000_0008, 32'hCAFE_F00D, 0, 1, 1, 1'b0, 2'b01, 1'b0,
                   4'b1111, 32'hCAFE_F00D, 0, 2'b00, 1'b1};
`ifdef MEM_ACCESS_TIMEOUT_EN
        tbl[8] = '{T_LOAD, 4'h2, 32'h0000_0001, 0, 32'h00AB_0000, 20, 0, 1'b0, 2'b10, 1'b0,
                   4'b0100, 0, 32'h0000_00AB, 2'b00, 1'b1};
`else
        tbl[8] = '{T_LOAD, 4'h2, 32'h0000_0001, 0, 32'h00AB_0000, 20, 0, 1'b0, 2'b10, 1'b0,
                   4'b0100, 0, 32'h0000_00AB, 2'b10, 1'b0};
`endif
        tbl[9] = '{T_MOV, 4'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 1'b1, 2'b11, 1'b1,
                   4'h0, 0, 32'hDEAD_BEEF, 2'b11, 1'b0};

        rst_i = 1'b0;
        ir_i = {32'h0, 4'(T_LOAD), 28'h0};
        result_i = 32'h0000_0104;
        repeat (2) @(negedge clk_i);
        chk("reset_ir", ir_o, 64'd0);
        chk("reset_pc", 64'(pc_o), 64'd0);
        chk("reset_result", 64'(result_o), 64'd0);
        chk("reset_misc", 64'({reg_write_o, halt_o, fault_o, bus_stb_o, bus_we_o, bus_sel_o}), 64'd0);
        chk("reset_cyc", 64'(bus_cyc_o), 64'd0);
        chk("reset_bus", 64'({bus_adr_o, bus_dat_o}), 64'd0);
        chk("reset_stall", 64'(stall_o), 64'd0);
        rst_i = 1'b1;

        for (int i = 0; i < 10; i++) run_op(tbl[i]);

        ir_i = {32'h0, 4'(T_LOAD), 28'h0};
        result_i = 32'h0000_0040;
        reg_write_i = 2'b11;
        @(negedge clk_i);
        chk("midrst_cyc_before", 64'(bus_cyc_o), 64'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_cyc", 64'(bus_cyc_o), 64'd0);
        chk("midrst_fault", 64'(fault_o), 64'd0);
        chk("midrst_reg_write", 64'(reg_write_o), 64'd0);
        chk("midrst_ir", ir_o, 64'd0);
        rst_i = 1'b1;
        ir_i = '0;
        @(negedge clk_i);
        chk("midrst_no_restart", 64'(bus_cyc_o), 64'd0);
        chk("midrst_no_fault", 64'(fault_o), 64'd0);

        for (int i = 0; i < 60; i++) begin
            logic mem;
            case ($urandom_range(0, 3))
                0:       rv.typ = T_ALU;
                1:       rv.typ = T_MOV;
                2:       rv.typ = T_LOAD;
                default: rv.typ = T_STORE;
            endcase
            rv.op     = 4'($urandom());
            rv.adr    = $urandom();
            rv.wdat   = $urandom();
            rv.bdat   = $urandom();
            rv.resp_k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 19))
                                                    : int'($urandom_range(1, 4));
            rv.resp   = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
            rv.stray  = ($urandom_range(0, 3) == 0);
            rv.rw     = 2'($urandom());
            rv.halt   = 1'($urandom());
            mem = (rv.typ == T_LOAD) || (rv.typ == T_STORE);
            rv.exp_sel   = model_sel(rv.op, rv.adr);
            rv.exp_dat   = model_st(rv.op, rv.wdat);
            rv.exp_fault = mem && ((rv.resp_k > TMO) || (rv.resp != 0));
            rv.exp_rw    = rv.exp_fault ? 2'b00 : rv.rw;
            rv.exp_res   = (rv.typ == T_LOAD) ? model_ld(rv.op, rv.adr, rv.bdat) : rv.adr;
            run_op(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
